// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter-side bundle for uart_tx_arbiter.
// slave: arbiter view; master: producers + transmitter view.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   grant;
  logic              wrn;
  logic [7:0]        d_in;
  logic              t_empty;
  logic              busy;
  logic              err;
  logic              err_clr;

  modport slave (
    input  req, data, t_empty, err_clr,
    output ack, grant, wrn, d_in, busy, err
  );

  modport master (
    output req, data, t_empty, err_clr,
    input  ack, grant, wrn, d_in, busy, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// Issues a one-cycle active-low write strobe, then waits for t_empty with a timeout.
module uart_tx_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 512,
  parameter int unsigned TW      = 10
) (
  input logic              clk16x,
  input logic              clr,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            wrn_q, wrn_d;
  logic [7:0]      d_in_q, d_in_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            err_q, err_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic [PW-1:0]   win_c;
  logic            found_c;
  logic            start_c;
  logic            done_c;
  logic            timeout_c;

  // Winner: first set req bit searching upward from ptr_q+1 with wrap.
  always_comb begin
    win_c   = ptr_q;
    found_c = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + k) % NREQ;
      if (!found_c && bus.req[idx]) begin
        win_c   = PW'(idx);
        found_c = 1'b1;
      end
    end
  end

  assign start_c   = (state_q == S_IDLE) && bus.t_empty && found_c;
  assign done_c    = (state_q == S_WAIT) && bus.t_empty;
  assign timeout_c = (state_q == S_WAIT) && !bus.t_empty && (cnt_q == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk16x or posedge clr) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_c) state_d = S_WRITE;
      S_WRITE: state_d = S_WAIT;
      S_WAIT:  if (done_c || timeout_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values
  always_comb begin
    wrn_d   = 1'b1;
    ack_d   = '0;
    d_in_d  = d_in_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_c) begin
          d_in_d  = bus.data[{win_c, 3'b000} +: 8];
          grant_d = NREQ'(1) << win_c;
          ack_d   = NREQ'(1) << win_c;
          wrn_d   = 1'b0;
          ptr_d   = win_c;
        end
      end
      S_WRITE: begin
        cnt_d = '0;
      end
      S_WAIT: begin
        if (done_c || timeout_c) grant_d = '0;
        else                     cnt_d   = cnt_q + TW'(1);
      end
      default: begin
        grant_d = '0;
      end
    endcase
    // Set beats clear when both land in the same cycle.
    if (bus.err_clr) err_d = 1'b0;
    if (timeout_c)   err_d = 1'b1;
  end

  always_ff @(posedge clk16x or posedge clr) begin
    if (clr) begin
      wrn_q   <= 1'b1;
      d_in_q  <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= PW'(NREQ - 1);
    end else begin
      wrn_q   <= wrn_d;
      d_in_q  <= d_in_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.wrn   = wrn_q;
  assign bus.d_in  = d_in_q;
  assign bus.ack   = ack_q;
  assign bus.grant = grant_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, round-robin order, t_empty gating,
// timeout/err handling and mid-transfer request changes.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 512;

  logic clk16x = 1'b0;
  logic clr;
  int   vectors = 0;
  int   errors  = 0;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(10)) dut (
    .clk16x (clk16x),
    .clr    (clr),
    .bus    (bus.slave)
  );

  initial forever #5 clk16x = ~clk16x;

  task automatic tick();
    @(posedge clk16x);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transfer starting in IDLE with t_empty=1; ends back in IDLE.
  task automatic xfer(input int idx, input logic [7:0] byte_v, input bit drop);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    tick();
    chk("write_wrn",   32'(bus.wrn),   32'h0);
    chk("write_ack",   32'(bus.ack),   32'(oh));
    chk("write_grant", 32'(bus.grant), 32'(oh));
    chk("write_d_in",  32'(bus.d_in),  32'(byte_v));
    if (drop) bus.req = '0;
    bus.t_empty = 1'b0;
    tick();
    chk("wait_wrn",   32'(bus.wrn),   32'h1);
    chk("wait_ack",   32'(bus.ack),   32'h0);
    chk("wait_grant", 32'(bus.grant), 32'(oh));
    tick();
    tick();
    chk("wait_d_in", 32'(bus.d_in), 32'(byte_v));
    chk("wait_busy", 32'(bus.busy), 32'h1);
    bus.t_empty = 1'b1;
    tick();
    chk("done_grant", 32'(bus.grant), 32'h0);
    chk("done_busy",  32'(bus.busy),  32'h0);
  endtask

  initial begin
    clr         = 1'b1;
    bus.req     = '0;
    bus.data    = '0;
    bus.t_empty = 1'b1;
    bus.err_clr = 1'b0;
    tick();
    tick();
    clr = 1'b0;
    chk("rst_wrn",   32'(bus.wrn),   32'h1);
    chk("rst_d_in",  32'(bus.d_in),  32'h0);
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_busy",  32'(bus.busy),  32'h0);
    chk("rst_err",   32'(bus.err),   32'h0);

    // Clear asserted mid-WAIT wipes everything immediately
    bus.data = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req  = 4'b1111;
    tick();
    chk("pre_clr_grant", 32'(bus.grant), 32'h1);
    chk("pre_clr_d_in",  32'(bus.d_in),  32'h11);
    bus.t_empty = 1'b0;
    tick();
    clr = 1'b1;
    #1;
    chk("clr_wrn",   32'(bus.wrn),   32'h1);
    chk("clr_d_in",  32'(bus.d_in),  32'h0);
    chk("clr_grant", 32'(bus.grant), 32'h0);
    chk("clr_ack",   32'(bus.ack),   32'h0);
    chk("clr_busy",  32'(bus.busy),  32'h0);
    chk("clr_err",   32'(bus.err),   32'h0);
    clr         = 1'b0;
    bus.t_empty = 1'b1;

    // All requesting: order 0,1,2,3,0,1,2,3
    for (int n = 0; n < 8; n++) begin
      logic [7:0] b;
      case (n % 4)
        0: b = 8'h11;
        1: b = 8'h22;
        2: b = 8'h33;
        default: b = 8'h44;
      endcase
      xfer(n % 4, b, n == 7);
    end

    // Single requester 2 with 0xA5; strobe low exactly one cycle
    bus.data = {8'h44, 8'hA5, 8'h22, 8'h11};
    bus.req  = 4'b0100;
    xfer(2, 8'hA5, 1'b1);

    // t_empty low in IDLE blocks the grant
    bus.req     = 4'b0001;
    bus.t_empty = 1'b0;
    tick();
    tick();
    tick();
    chk("blk_wrn",  32'(bus.wrn),  32'h1);
    chk("blk_busy", 32'(bus.busy), 32'h0);
    bus.t_empty = 1'b1;
    tick();
    chk("unblk_wrn",   32'(bus.wrn),   32'h0);
    chk("unblk_grant", 32'(bus.grant), 32'h1);
    bus.req = '0;
    tick();
    tick();
    chk("unblk_idle", 32'(bus.busy), 32'h0);

    // Timeout: requester 1, t_empty stuck low
    bus.req = 4'b0010;
    tick();
    chk("to1_grant", 32'(bus.grant), 32'h2);
    bus.req     = '0;
    bus.t_empty = 1'b0;
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("to1_err_early", 32'(bus.err),  32'h0);
    chk("to1_busy_early", 32'(bus.busy), 32'h1);
    tick();
    chk("to1_err",   32'(bus.err),   32'h1);
    chk("to1_busy",  32'(bus.busy),  32'h0);
    chk("to1_grant_clr", 32'(bus.grant), 32'h0);

    // err does not block arbitration; clear coincident with new timeout keeps err
    bus.t_empty = 1'b1;
    bus.req     = 4'b0010;
    tick();
    chk("to2_grant", 32'(bus.grant), 32'h2);
    chk("to2_err",   32'(bus.err),   32'h1);
    bus.req     = '0;
    bus.t_empty = 1'b0;
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("to2_err_set_wins", 32'(bus.err),  32'h1);
    chk("to2_busy",         32'(bus.busy), 32'h0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("err_cleared", 32'(bus.err), 32'h0);

    // Request change during WAIT leaves the current transfer alone
    bus.t_empty = 1'b1;
    bus.data    = {8'hC3, 8'h33, 8'h5A, 8'h11};
    bus.req     = 4'b0010;
    tick();
    chk("chg_grant", 32'(bus.grant), 32'h2);
    bus.t_empty = 1'b0;
    tick();
    bus.req = 4'b1000;
    tick();
    tick();
    chk("chg_grant_held", 32'(bus.grant), 32'h2);
    chk("chg_d_in_held",  32'(bus.d_in),  32'h5A);
    chk("chg_ack_quiet",  32'(bus.ack),   32'h0);
    bus.t_empty = 1'b1;
    tick();
    chk("chg_done", 32'(bus.grant), 32'h0);
    xfer(3, 8'hC3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and write sequencer that shares one UART transmitter among NREQ byte producers. It picks a requester, drives the transmitter's active-low write strobe and data byte, and waits for the transmitter to report empty before granting again. It sits between the CPU-side producers and the transmitter's wrn/d_in/t_empty ports, in the clk16x domain. A timeout detects a transmitter that never returns to empty.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 512, clk16x cycles allowed in WAIT before flagging an error (must exceed one full frame, 12*16 cycles)
TW, 10, timeout counter width (2**TW > TIMEOUT)

Ports:
clk16x  in  1  baud*16 clock, shared with transmitter
clr  in  1  asynchronous active-high reset
req  in  NREQ  per-requester byte-valid, level; held with data until ack
data  in  8*NREQ  packed bytes, requester i at [8*i+7:8*i]
ack  out  NREQ  one-hot one-cycle pulse: requester's byte handed to transmitter
grant  out  NREQ  one-hot owner of current transfer, held WRITE through WAIT
wrn  out  1  transmitter write strobe, active low
d_in  out  8  byte to transmitter
t_empty  in  1  transmitter empty/ready
busy  out  1  state != IDLE
err  out  1  sticky timeout flag
err_clr  in  1  clears err

Behaviour:
- All outputs registered on posedge clk16x. clr asserted: state=IDLE, wrn=1, d_in=0, ack=0, grant=0, err=0, timeout count=0, round-robin pointer=NREQ-1 (requester 0 highest priority after reset). Takes effect immediately, including mid-WRITE/WAIT; no partial strobe survives.
- States: IDLE, WRITE, WAIT.
- IDLE: if t_empty==1 and req!=0, select winner w = first set req bit searching upward (with wrap) from pointer+1; load d_in<=data[w], grant<=onehot(w), ack<=onehot(w), wrn<=0, pointer<=w, go to WRITE. If t_empty==0 or req==0, stay; wrn stays 1.
- WRITE: lasts exactly one cycle. wrn=0 and ack[w]=1 during it. Next edge: wrn<=1, ack<=0, count<=0, go to WAIT. d_in is held stable through WRITE and WAIT.
- WAIT: t_empty is sampled at each edge. The first sampled t_empty==0 after wrn rises may be stale; the block does not require seeing it low. On t_empty==1: grant<=0, go to IDLE. Else count++. If count reaches TIMEOUT-1: err<=1, grant<=0, go to IDLE.
- Minimum per-byte spacing is 3 cycles (IDLE->WRITE->WAIT->IDLE). A new grant needs t_empty==1 in IDLE.
- Requesters may keep req high after ack to send the next byte. They are re-arbitrated with pointer already advanced, so there is no back-to-back win while others wait. Requests that arrive or drop during WRITE/WAIT do not affect the current transfer. req dropped before ack while in IDLE: simply not selected.
- err: sticky until err_clr. If err_clr and a timeout set happen in the same cycle, set wins. err does not block arbitration.
- Exactly one of grant bits is set, or none. ack is a subset of grant.

Test Plan:
1. Assert clr mid-stream -> immediately wrn=1, d_in=0x00, grant=0, ack=0, busy=0, err=0. After release, all req high -> first grant is requester 0.
2. req=4'b0100, data[23:16]=0xA5, real transmitter attached -> wrn low for exactly 1 cycle, d_in=0xA5, ack=4'b0100 in the same cycle. grant=4'b0100 until t_empty returns. txd frame: start bit, 1,0,1,0,0,1,0,1, parity 0, stop.
3. req=4'b1111 held, 8 bytes -> ack order 0,1,2,3,0,1,2,3; each ack has d_in equal to that requester's byte.
4. t_empty forced 0 in IDLE with req=4'b0001 -> wrn stays 1, busy=0. Release t_empty -> WRITE on the next edge.
5. t_empty stuck 0 after WRITE -> err=1 after TIMEOUT (512) cycles in WAIT, state returns to IDLE. err_clr pulse -> err=0. err_clr coincident with a new timeout -> err=1.
6. req[1] dropped during WAIT and req[3] raised -> current transfer completes unchanged, next grant is requester 3.
